// File: rtl/popcount_seg_accum_if.sv
// Data/display bundle for popcount_seg_accum: counted input bits and mode go in,
// registered seven-segment pattern and decimal point come out.
interface popcount_seg_accum_if #(
    parameter int N_IN = 6
);
    logic [N_IN-1:0] din;
    logic            mode;
    logic [6:0]      seg;
    logic            dp;

    modport master (output din, output mode, input seg, input dp);
    modport slave  (input din, input mode, output seg, output dp);
endinterface

// File: rtl/popcount_seg_accum.sv
// Three-stage ones counter (live or saturating accumulate) driving a hex seven-segment digit.
// Optional digit scanning across the accumulator nibbles: POPCOUNT_SEG_DIGIT_SCAN_EN.
module popcount_seg_accum #(
    parameter int N_IN     = 6,
    parameter int ACC_W    = 8,
    parameter int SCAN_DIV = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    popcount_seg_accum_if.slave  bus
);
    localparam int PW   = $clog2(N_IN + 1);
    localparam int NDIG = ACC_W / 4;
    localparam logic [ACC_W-1:0] VMAX = '1;

    logic [PW-1:0]    w_pop;
    logic [PW-1:0]    r_pop;
    logic             r_modeQ;
    logic             r_modeQQ;
    logic [ACC_W-1:0] r_value;
    logic [ACC_W:0]   w_sum;
    logic [3:0]       w_nibble;
    logic [6:0]       r_seg;
    logic             r_dp;

    function automatic logic [6:0] hexFont(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
            4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
            4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
            4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
        endcase
        return f;
    endfunction

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_pop = w_pop + PW'(bus.din[i]);
        end
    end

    // One extra bit lets the clamp detect overflow without ever wrapping.
    assign w_sum = {1'b0, r_value} + (ACC_W + 1)'(r_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop    <= '0;
            r_modeQ  <= 1'b0;
            r_modeQQ <= 1'b0;
            r_value  <= '0;
        end else begin
            r_pop    <= w_pop;
            r_modeQ  <= bus.mode;
            r_modeQQ <= r_modeQ;
            if (!r_modeQ || !r_modeQQ) begin
                r_value <= ACC_W'(r_pop);
            end else if (w_sum[ACC_W]) begin
                r_value <= VMAX;
            end else begin
                r_value <= w_sum[ACC_W-1:0];
            end
        end
    end

`ifdef POPCOUNT_SEG_DIGIT_SCAN_EN
    localparam int CW  = $clog2(SCAN_DIV);
    localparam int DSW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]  r_scanCnt;
    logic [DSW-1:0] r_digSel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scanCnt <= '0;
            r_digSel  <= '0;
        end else if (r_scanCnt == CW'(SCAN_DIV - 1)) begin
            r_scanCnt <= '0;
            r_digSel  <= (r_digSel == DSW'(NDIG - 1)) ? '0 : r_digSel + DSW'(1);
        end else begin
            r_scanCnt <= r_scanCnt + CW'(1);
        end
    end

    always_comb begin
        w_nibble = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (r_digSel == DSW'(d)) begin
                w_nibble = r_value[4*d +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h3F;
            r_dp  <= 1'b0;
        end else begin
            r_seg <= hexFont(w_nibble);
            r_dp  <= (r_digSel == DSW'(NDIG - 1));
        end
    end
`else
    logic r_sat;

    // Sticky clamp flag; any live cycle or fresh accumulate entry clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (!r_modeQ || !r_modeQQ) begin
            r_sat <= 1'b0;
        end else if (w_sum[ACC_W]) begin
            r_sat <= 1'b1;
        end
    end

    assign w_nibble = r_value[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h3F;
            r_dp  <= 1'b0;
        end else begin
            r_seg <= hexFont(w_nibble);
            r_dp  <= r_sat;
        end
    end
`endif

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
endmodule

// File: tb/tb_popcount_seg_accum.sv
// Scoreboard bench for popcount_seg_accum: a sample-level model predicts each displayed digit,
// a posedge+2 monitor pops and compares. Honours POPCOUNT_SEG_DIGIT_SCAN_EN if defined.
module tb_popcount_seg_accum;
    localparam int N_IN     = 6;
    localparam int ACC_W    = 8;
    localparam int SCAN_DIV = 4;
    localparam int NDIG     = ACC_W / 4;
    localparam int VMAX     = (1 << ACC_W) - 1;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        int         k;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    popcount_seg_accum_if #(.N_IN(N_IN)) bus ();

    popcount_seg_accum #(.N_IN(N_IN), .ACC_W(ACC_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t expQ[$];
    int   checks    = 0;
    int   passed    = 0;
    bit   monitorOn = 1'b0;

    int   mVal;
    bit   mSat;
    bit   mPrevMode;
    int   sampleIdx;

    // Displayed output after clock edge k reflects the sample taken at edge k-2.
    function automatic exp_t expectFor(input int k, input int val, input bit sat);
        exp_t e;
        int   d;
`ifdef POPCOUNT_SEG_DIGIT_SCAN_EN
        d     = ((k - 1) / SCAN_DIV) % NDIG;
        e.dp  = (d == NDIG - 1);
`else
        d     = 0;
        e.dp  = sat;
`endif
        e.seg = font[(val >> (4 * d)) & 15];
        e.k   = k;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] aSeg, input logic aDp,
                               input logic [6:0] eSeg, input logic eDp);
        checks++;
        if (aSeg === eSeg && aDp === eDp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got seg=%h dp=%b, expected seg=%h dp=%b",
                     name, aSeg, aDp, eSeg, eDp);
        end
    endtask

    task automatic resetModel();
        mVal      = 0;
        mSat      = 1'b0;
        mPrevMode = 1'b0;
        sampleIdx = 0;
        expQ.delete();
        expQ.push_back(expectFor(1, 0, 1'b0));
        expQ.push_back(expectFor(2, 0, 1'b0));
    endtask

    // Drive one sample for the coming edge, predict its display, then wait a cycle.
    task automatic applyStimulus(input logic [N_IN-1:0] d, input logic m);
        int pop;
        bus.din  = d;
        bus.mode = m;
        sampleIdx++;
        pop = $countones(d);
        if (!m || !mPrevMode) begin
            mVal = pop;
            mSat = 1'b0;
        end else if (mVal + pop > VMAX) begin
            mVal = VMAX;
            mSat = 1'b1;
        end else begin
            mVal = mVal + pop;
        end
        mPrevMode = m;
        expQ.push_back(expectFor(sampleIdx + 2, mVal, mSat));
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #2;
        if (monitorOn) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboard underflow", bus.seg, bus.dp, 7'h00, 1'b0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("edge %0d", e.k), bus.seg, bus.dp, e.seg, e.dp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic m;
        bus.din  = '1;
        bus.mode = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset hold", bus.seg, bus.dp, 7'h3F, 1'b0);

        rst_n = 1'b1;
        resetModel();
        monitorOn = 1'b1;
        repeat (3) applyStimulus(6'b111111, 1'b0);

        applyStimulus(6'b101001, 1'b0);
        applyStimulus(6'b000000, 1'b0);
        applyStimulus(6'b000000, 1'b0);

        repeat (3) applyStimulus(6'b111111, 1'b1);
        applyStimulus(6'b000000, 1'b0);

        repeat (43) applyStimulus(6'b111111, 1'b1);
        repeat (3) applyStimulus(6'b111111, 1'b1);
        repeat (3) applyStimulus(6'b111111, 1'b0);

        repeat (7) applyStimulus(6'b111111, 1'b1);
        repeat (12) applyStimulus(6'b000000, 1'b1);

        m = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(7) == 0) m = ~m;
            if ($urandom_range(3) == 0) applyStimulus('1, m);
            else applyStimulus(N_IN'($urandom), m);
        end

        repeat (5) applyStimulus(6'b110110, 1'b1);
        #2;
        monitorOn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", bus.seg, bus.dp, 7'h3F, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset held", bus.seg, bus.dp, 7'h3F, 1'b0);

        rst_n = 1'b1;
        resetModel();
        monitorOn = 1'b1;
        repeat (4) applyStimulus(6'b000111, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9) == 0) m = ~m;
            if ($urandom_range(2) == 0) applyStimulus('1, m);
            else applyStimulus(N_IN'($urandom), m);
        end
        repeat (4) applyStimulus(6'b000000, 1'b0);

        monitorOn = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/popcount_seg_accum.md
# popcount_seg_accum

Parametrised, clocked ones-counter with a seven-segment readout for a user-module tile. It registers the population count of an N_IN-bit input bus each cycle. Two modes: live (count shown directly) and accumulate (saturating running sum since accumulate mode was entered). The selected hex digit is decoded onto registered active-high segment outputs that drive the tile's io_out pins.

## Interface
- N_IN, default 6: number of data input bits counted; 1..15, and N_IN < 2^ACC_W.
- ACC_W, default 8: accumulator width in bits; multiple of 4, 4..16.
- SCAN_DIV, default 1024: cycles per displayed digit when scanning; ≥ 2.

- clk  input  1: single clock, all state on rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- din  input  N_IN: data bits whose ones are counted; synchronous to clk.
- mode  input  1: 0 = live, 1 = accumulate; synchronous to clk.
- seg  output  7: segments a..g on bits 0..6, active-high, registered.
- dp  output  1: decimal point, registered; meaning depends on DIGIT_SCAN_EN.

## Operation
- Stage 1: `pop_q <= popcount(din)`, width `$clog2(N_IN+1)`. `mode_q <= mode` and `mode_qq <= mode_q`.
- Stage 2 updates `value`, ACC_W bits:
  - `mode_q=0`: `value <= pop_q`, zero-extended.
  - `mode_q=1, mode_qq=0` (accumulate entry): `value <= pop_q`. This discards the prior value, so no separate clear cycle is needed.
  - `mode_q=1, mode_qq=1`: `value <= min(value + pop_q, 2^ACC_W-1)`. Compute the sum one bit wider, then clamp.
  - Sticky flag `sat`: set when a clamp occurs. Cleared on accumulate entry, while `mode_q=0`, and on reset.
- Stage 3 decodes the selected nibble of `value` to `seg`. Hex font, bit6..0 = g..a:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- Mode toggling mid-accumulate: returning to 0 makes `value` track live counts immediately. Re-entering 1 restarts the sum.
- Reset mid-operation clears every register asynchronously. Operation resumes from the reset state on the first edge after rst_n rises.

## Timing
- Reset values: `pop_q=0`, `mode_q=0`, `mode_qq=0`, `value=0`, `sat=0`, scan counter 0, digit select 0, `seg=0x3F`, `dp=0`.
- Latency from din/mode sample to `seg`: 3 clock edges. Throughput: one sample per cycle.
- Saturation clamps in the same cycle that would overflow. Stage 2 never wraps.
- Scan counter and digit select change only in accumulate or live alike. Scanning is free-running and independent of mode.

## Configuration
- Macro: `POPCOUNT_SEG_DIGIT_SCAN_EN`.
- Defined:
  - The scan counter counts 0..SCAN_DIV-1. At terminal count, digit select advances modulo ACC_W/4.
  - `seg` shows the nibble at the current digit select.
  - `dp=1` while the most-significant nibble is shown, otherwise 0.
  - `sat` is not output; a saturated value shows all-F digits.
- Undefined:
  - No scan counter or digit select logic.
  - `seg` always shows nibble 0 of `value`.
  - `dp = sat`, registered with `seg`.

## Test plan
- Reset: hold rst_n=0 with din all-ones. Release → `seg=0x3F`, `dp=0` until edge 3 after release; then `seg=0x7D` (6).
- Live mode, N_IN=6, macro undefined: apply din=6'b101001 then 6'b000000 on consecutive cycles → `seg=0x4F` (3), then `0x3F`, each 3 edges after its din cycle.
- Accumulate entry: mode 0→1 with din=6'b111111 held for 3 cycles, macro undefined → `seg` sequence 6, C, 2 (0x7D, 0x39, 0x5B). Internal `value` sequence 6, 12, 18 (0x12).
- Saturation, ACC_W=8: accumulate din all-ones for 43 cycles (258 ones).
  - Macro undefined: `value` clamps at 0xFF, `seg=0x71`, `dp` goes 1 on the clamp cycle.
  - Then mode→0: `dp` returns to 0 and `seg` shows the live 6.
- Scan, macro defined, SCAN_DIV=4, `value`=0x2A in live mode (din held so popcount=0x2A is not possible; preload via accumulate to 0x2A, then hold din=0) → `seg` alternates 0x77 (dp=0) / 0x5B (dp=1), each phase 4 cycles.
- Async reset mid-accumulate: assert rst_n=0 between edges → `seg=0x3F`, `dp=0` immediately, without waiting for a clk edge. After release, accumulation restarts from 0.
